counter4: RTL and testbench

COUNTER4 -- requirements
Module: counter4

---
 rtl/counter_pkg.sv | 9 +
 rtl/counter_next.sv | 50 +++++
 rtl/counter4.sv | 47 ++++
 tb/tb_counter4.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter family: count direction encoding and
// the default counter width.
package counter_pkg;

    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
    localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_next.sv
// Next-state logic for the up/down counter: increment/decrement, wrap or
// saturate at the end values, and the terminal-count indication.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] next_count,
    output logic             next_tc
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    // An enabled step off either end counts as terminal, whether it wraps or is blocked.
    always_comb begin
        next_count = count;
        next_tc    = 1'b0;
        if (en) begin
            case (up)
                DIR_UP: begin
                    if (count == MAX_VAL) begin
                        next_tc    = 1'b1;
                        next_count = SATURATE ? count : MIN_VAL;
                    end else begin
                        next_count = count + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (count == MIN_VAL) begin
                        next_tc    = 1'b1;
                        next_count = SATURATE ? count : MAX_VAL;
                    end else begin
                        next_count = count - ONE;
                    end
                end
                default: begin
                    next_count = count;
                    next_tc    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter4.sv
// Up/down counter with registered count and terminal-count pulse, plus
// combinational zero/max flags decoded from the count register.
module counter4
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero,
    output logic             max
);

    logic [WIDTH-1:0] next_count;
    logic             next_tc;

    counter_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .en         (en),
        .up         (up),
        .next_count (next_count),
        .next_tc    (next_tc)
    );

    // rst is active-low and clears both registers without waiting for clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= next_tc;
        end
    end

    assign zero = (count == '0);
    assign max  = (count == '1);

endmodule

// File: tb/tb_counter4.sv
// Directed self-checking bench for counter4: a wrapping instance, a
// saturating instance, and a wrapping instance counting the opposite way.
module tb_counter4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       up_n;

    logic [3:0] cnt_w, cnt_s, cnt_o;
    logic       tc_w, tc_s, tc_o;
    logic       zero_w, zero_s, zero_o;
    logic       max_w, max_s, max_o;

    int checks = 0;
    int errors = 0;

    assign up_n = ~up;

    counter4 #(.WIDTH(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up),
        .count(cnt_w), .tc(tc_w), .zero(zero_w), .max(max_w)
    );

    counter4 #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up),
        .count(cnt_s), .tc(tc_s), .zero(zero_s), .max(max_s)
    );

    counter4 #(.WIDTH(4), .SATURATE(1'b0)) dut_opp (
        .clk(clk), .rst(rst), .en(en), .up(up_n),
        .count(cnt_o), .tc(tc_o), .zero(zero_o), .max(max_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic e, input logic u);
        rst = r;
        en  = e;
        up  = u;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, " cnt_w"}, 16'(cnt_w), 16'h0);
        checkOutput({tag, " cnt_s"}, 16'(cnt_s), 16'h0);
        checkOutput({tag, " cnt_o"}, 16'(cnt_o), 16'h0);
        checkOutput({tag, " tc_w"}, 16'(tc_w), 16'h0);
        checkOutput({tag, " tc_s"}, 16'(tc_s), 16'h0);
        checkOutput({tag, " tc_o"}, 16'(tc_o), 16'h0);
        checkOutput({tag, " zero_w"}, 16'(zero_w), 16'h1);
        checkOutput({tag, " max_w"}, 16'(max_w), 16'h0);
        checkOutput({tag, " zero_o"}, 16'(zero_o), 16'h1);
        checkOutput({tag, " max_s"}, 16'(max_s), 16'h0);
    endtask

    initial begin
        logic [3:0] exp_w, exp_o;

        applyStimulus(1'b1, 1'b0, 1'b1);
        #1 rst = 1'b0;
        #1 checkAllReset("reset_async");
        tick();
        checkAllReset("reset_held");

        // Count up 10 cycles; opposite instance counts down from 0.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checkOutput($sformatf("up10 cnt_w %0d", i), 16'(cnt_w), 16'(i));
            checkOutput($sformatf("up10 tc_w %0d", i), 16'(tc_w), 16'h0);
            checkOutput($sformatf("up10 cnt_s %0d", i), 16'(cnt_s), 16'(i));
            checkOutput($sformatf("up10 cnt_o %0d", i), 16'(cnt_o), 16'(16 - i));
            checkOutput($sformatf("up10 tc_o %0d", i), 16'(tc_o), (i == 1) ? 16'h1 : 16'h0);
            checkOutput($sformatf("up10 max_o %0d", i), 16'(max_o), (i == 1) ? 16'h1 : 16'h0);
        end

        // Reverse direction at count 10 for 8 cycles.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checkOutput($sformatf("dn8 cnt_w %0d", i), 16'(cnt_w), 16'(10 - i));
            checkOutput($sformatf("dn8 cnt_s %0d", i), 16'(cnt_s), 16'(10 - i));
            checkOutput($sformatf("dn8 cnt_o %0d", i), 16'(cnt_o), 16'(6 + i));
            checkOutput($sformatf("dn8 tc_w %0d", i), 16'(tc_w), 16'h0);
        end

        // Asynchronous reset between clock edges.
        #3 rst = 1'b0;
        #1 checkAllReset("reset_midcycle");

        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        checkAllReset("release_en0");

        // Hold with en=0 while up toggles.
        for (int i = 0; i < 5; i++) begin
            up = ~up;
            tick();
            checkOutput($sformatf("hold0 cnt_w %0d", i), 16'(cnt_w), 16'h0);
            checkOutput($sformatf("hold0 tc_w %0d", i), 16'(tc_w), 16'h0);
        end

        // Count up 18 cycles from 0: wrap, saturate and opposite direction.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 18; i++) begin
            tick();
            exp_w = 4'(i);
            exp_o = 4'(16 - i);
            checkOutput($sformatf("up18 cnt_w %0d", i), 16'(cnt_w), 16'(exp_w));
            checkOutput($sformatf("up18 tc_w %0d", i), 16'(tc_w), (i == 16) ? 16'h1 : 16'h0);
            checkOutput($sformatf("up18 max_w %0d", i), 16'(max_w), (i == 15) ? 16'h1 : 16'h0);
            checkOutput($sformatf("up18 zero_w %0d", i), 16'(zero_w), (i == 16) ? 16'h1 : 16'h0);
            checkOutput($sformatf("up18 cnt_s %0d", i), 16'(cnt_s), (i >= 15) ? 16'hF : 16'(i));
            checkOutput($sformatf("up18 tc_s %0d", i), 16'(tc_s), (i >= 16) ? 16'h1 : 16'h0);
            checkOutput($sformatf("up18 cnt_o %0d", i), 16'(cnt_o), 16'(exp_o));
            checkOutput($sformatf("up18 tc_o %0d", i), 16'(tc_o),
                        (i == 1 || i == 17) ? 16'h1 : 16'h0);
        end

        // en=0 with up toggling: all counts frozen, tc cleared.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up = ~up;
            tick();
            checkOutput($sformatf("hold1 cnt_w %0d", i), 16'(cnt_w), 16'h2);
            checkOutput($sformatf("hold1 cnt_s %0d", i), 16'(cnt_s), 16'hF);
            checkOutput($sformatf("hold1 cnt_o %0d", i), 16'(cnt_o), 16'hE);
            checkOutput($sformatf("hold1 tc_s %0d", i), 16'(tc_s), 16'h0);
            checkOutput($sformatf("hold1 tc_o %0d", i), 16'(tc_o), 16'h0);
        end

        // Saturating instance pinned at max for 20 enabled up cycles.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_w = 4'(2 + i);
            exp_o = 4'(14 - i);
            checkOutput($sformatf("sat20 cnt_s %0d", i), 16'(cnt_s), 16'hF);
            checkOutput($sformatf("sat20 tc_s %0d", i), 16'(tc_s), 16'h1);
            checkOutput($sformatf("sat20 max_s %0d", i), 16'(max_s), 16'h1);
            checkOutput($sformatf("sat20 cnt_w %0d", i), 16'(cnt_w), 16'(exp_w));
            checkOutput($sformatf("sat20 tc_w %0d", i), 16'(tc_w), (i == 14) ? 16'h1 : 16'h0);
            checkOutput($sformatf("sat20 cnt_o %0d", i), 16'(cnt_o), 16'(exp_o));
            checkOutput($sformatf("sat20 tc_o %0d", i), 16'(tc_o), (i == 15) ? 16'h1 : 16'h0);
        end

        // Fresh reset, then count down: saturation blocks at 0.
        #3 rst = 1'b0;
        #1 checkAllReset("reset_again");
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("dn3 cnt_s %0d", i), 16'(cnt_s), 16'h0);
            checkOutput($sformatf("dn3 tc_s %0d", i), 16'(tc_s), 16'h1);
            checkOutput($sformatf("dn3 zero_s %0d", i), 16'(zero_s), 16'h1);
            checkOutput($sformatf("dn3 cnt_w %0d", i), 16'(cnt_w), 16'(16 - i));
            checkOutput($sformatf("dn3 tc_w %0d", i), 16'(tc_w), (i == 1) ? 16'h1 : 16'h0);
            checkOutput($sformatf("dn3 cnt_o %0d", i), 16'(cnt_o), 16'(i));
            checkOutput($sformatf("dn3 tc_o %0d", i), 16'(tc_o), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
